// File: rtl/lsu_mem_initiator_pkg.sv
// Shared constants and state encoding for the load/store initiator,
// also used by the data memory and core for matching bus widths.
package lsu_mem_initiator_pkg;

  localparam int unsigned LSU_ADDR_W = 16;
  localparam int unsigned LSU_DATA_W = 16;
  localparam int unsigned LSU_LEN_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_rsp_reg.sv
// One-entry read response register; issue_o tells the reader a new beat
// may be captured this cycle without overwriting an unconsumed one.
module lsu_rsp_reg #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              issue_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  assign issue_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns single/burst requests into single-port memory
// accesses, returning read data through a backpressured response register.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned LEN_W  = LSU_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              done_q;
  logic              issue;
  logic              rd_load;

  assign rd_load = (state_q == S_READ) && issue;

  lsu_rsp_reg #(
    .DATA_W(DATA_W)
  ) u_rsp_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rd_load),
    .data_i (mem_read_data),
    .last_i (cnt_q == '0),
    .ready_i(rsp_ready),
    .valid_o(rsp_valid),
    .data_o (rsp_data),
    .last_o (rsp_last),
    .issue_o(issue)
  );

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign wr_ready        = (state_q == S_WRITE);
  assign mem_write_en    = (state_q == S_WRITE) && wr_valid;
  assign mem_write_data  = (state_q == S_WRITE) ? wr_data : '0;
  assign mem_read        = rd_load;
  assign mem_access_addr = cur_addr_q;
  assign done            = done_q;

  // cnt_q holds beats remaining minus one, so zero marks the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cur_addr_q <= req_addr;
            cnt_q      <= req_len;
            state_q    <= req_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            cur_addr_q <= cur_addr_q + 1'b1;
            cnt_q      <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            cur_addr_q <= cur_addr_q + 1'b1;
            cnt_q      <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench: table of requests against a memory model, with
// scoreboard queues for expected writes and read responses.
module tb_lsu_mem_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [2:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [15:0] rsp_data;
  logic        done, busy;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wexp_t;
  typedef struct packed { logic [15:0] d; logic l; } rexp_t;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [2:0]  len;
    logic [15:0] base;
    logic [7:0]  pat;    // write: gap before beat i; read: rsp_ready at cycle i
    logic [15:0] end_a;
  } vec_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  vec_t        vecs[8];
  logic [15:0] exp_issue;
  int unsigned total, bad, done_cnt, pops;

  lsu_mem_initiator #(.ADDR_W(16), .DATA_W(16), .LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .done(done), .busy(busy),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_access_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    wexp_t w;
    rexp_t r;
    if (mem_write_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(mem_access_addr), 32'hFFFF_FFFF);
      else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(mem_access_addr), 32'(w.a));
        chk("wr_data", 32'(mem_write_data), 32'(w.d));
      end
    end
    if (mem_read) begin
      chk("rd_addr", 32'(mem_access_addr), 32'(exp_issue));
      exp_issue++;
    end
    if (rsp_valid && !rsp_ready) chk("rd_stall", 32'(mem_read), 32'd0);
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      else begin
        r = rq.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(r.d));
        chk("rsp_last", 32'(rsp_last), 32'(r.l));
      end
      pops++;
    end
    if (done) done_cnt++;
  endtask

  // Sample mid-cycle, then let the edge happen; memory commits what the edge saw.
  task automatic tick();
    logic        pend;
    logic [15:0] pa, pd;
    @(negedge clk);
    pend = mem_write_en;
    pa   = mem_access_addr;
    pd   = mem_write_data;
    monitor();
    @(posedge clk);
    #1;
    if (pend) mem[pa] = pd;
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s act=timeout exp=complete", nm);
  endtask

  task automatic do_req(input vec_t v);
    int unsigned d0;
    int          n;
    logic [15:0] a;
    d0 = done_cnt;
    n  = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) timeout("req_ready");
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_len   = v.len;
    if (!v.we) begin
      exp_issue = v.addr;
      for (int i = 0; i <= int'(v.len); i++)
        rq.push_back('{d: ref_mem[v.addr + 16'(i)], l: (i == int'(v.len))});
    end
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    if (v.we) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        if (v.pat[i]) begin wr_valid = 1'b0; tick(); end
        wr_valid = 1'b1;
        wr_data  = v.base + 16'(i);
        a        = v.addr + 16'(i);
        wq.push_back('{a: a, d: wr_data});
        ref_mem[a] = wr_data;
        tick();
      end
      wr_valid = 1'b0;
    end else begin
      for (int c = 0; c < 200 && (rq.size() != 0 || busy); c++) begin
        rsp_ready = (c < 8) ? v.pat[c] : 1'b1;
        tick();
      end
      rsp_ready = 1'b0;
    end
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    if (busy) timeout("busy_clear");
    tick();
    tick();
    chk("done_once", done_cnt - d0, 32'd1);
    chk("end_addr", 32'(mem_access_addr), 32'(v.end_a));
    chk("rq_empty", rq.size(), 32'd0);
    chk("wq_empty", wq.size(), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   n;
    int unsigned d0;
    total = 0; bad = 0; done_cnt = 0; pops = 0; exp_issue = '0;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    vecs[0] = '{we: 1'b1, addr: 16'h0003, len: 3'd0, base: 16'hA5A5, pat: 8'b0000_0001, end_a: 16'h0004};
    vecs[1] = '{we: 1'b1, addr: 16'h0006, len: 3'd3, base: 16'h0001, pat: 8'b0000_0100, end_a: 16'h000A};
    vecs[2] = '{we: 1'b0, addr: 16'h0003, len: 3'd0, base: 16'h0000, pat: 8'b1111_1111, end_a: 16'h0004};
    vecs[3] = '{we: 1'b0, addr: 16'h0006, len: 3'd3, base: 16'h0000, pat: 8'b1101_1001, end_a: 16'h000A};
    vecs[4] = '{we: 1'b1, addr: 16'hFFFF, len: 3'd1, base: 16'h1111, pat: 8'b0000_0000, end_a: 16'h0001};
    vecs[5] = '{we: 1'b0, addr: 16'hFFFF, len: 3'd1, base: 16'h0000, pat: 8'b1111_1111, end_a: 16'h0001};
    vecs[6] = '{we: 1'b1, addr: 16'h0010, len: 3'd7, base: 16'h0100, pat: 8'b0000_0000, end_a: 16'h0018};
    vecs[7] = '{we: 1'b0, addr: 16'h0010, len: 3'd7, base: 16'h0000, pat: 8'b1010_1010, end_a: 16'h0018};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrl", 32'({wr_ready, rsp_valid, rsp_last, done, mem_write_en, mem_read}), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_addr", 32'(mem_access_addr), 32'd0);
    chk("rst_wdata", 32'(mem_write_data), 32'd0);
    #3 rst_n = 1'b1;
    repeat (2) tick();
    chk("rst_no_done", done_cnt, 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);

    for (int k = 0; k < 8; k++) do_req(vecs[k]);
    chk("mem3_readback", 32'(mem[16'h0003]), 32'hA5A5);

    // Reset during an 8-beat read after two responses have been accepted.
    d0 = done_cnt;
    pops = 0;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_len = 3'd7;
    exp_issue = 16'h0010;
    for (int i = 0; i < 8; i++)
      rq.push_back('{d: ref_mem[16'h0010 + 16'(i)], l: (i == 7)});
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (pops < 2 && n < 20) begin tick(); n++; end
    if (pops < 2) timeout("mid_read_pops");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    rq.delete();
    rsp_ready = 1'b0;
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_no_done", done_cnt - d0, 32'd0);

    v = '{we: 1'b1, addr: 16'h0000, len: 3'd0, base: 16'h5A5A, pat: 8'b0000_0000, end_a: 16'h0001};
    do_req(v);
    v = '{we: 1'b0, addr: 16'h0000, len: 3'd0, base: 16'h0000, pat: 8'b1111_1111, end_a: 16'h0001};
    do_req(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
